// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED scan controller and the 7-seg decoder it feeds
package led_pkg;
  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;
  localparam int DP_BIT = 4;
  typedef logic [4:0] dig_code_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler counting 0..i_limit while enabled, pulsing o_tick on terminal count
//   clk, rst_n (sync, active-low) | i_en: count enable | i_limit: terminal value | o_tick: terminal-count strobe
module led_tick_gen
  import led_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tick
);
  logic [W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == i_limit);
  always_ff @(posedge clk)
    if (!rst_n) r_cnt <= '0;
    else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: double-buffered time-multiplexed scan controller for a common-anode 7-seg display
//   clk, rst_n (sync, active-low) | en: scan enable | i_data/i_dp: digit nibbles and decimal points
//   i_load: capture strobe | o_dig_ctrl: {dp,nibble} to decoder | o_an: active-low digit enables
//   o_frame: pulse at start of slot 0 | LED_SCAN_BLANK_EN: adds an all-off phase before each digit
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  output logic [4:0]              o_dig_ctrl,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int W = $clog2(CNT_MAX);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
`ifdef LED_SCAN_BLANK_EN
  localparam scan_state_e ST_FIRST = ST_BLANK;
`else
  localparam scan_state_e ST_FIRST = ST_DRIVE;
`endif
  scan_state_e             r_state, w_state_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [W-1:0]            w_limit;
  logic                    w_tick, w_adv, w_wrap;
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data, w_act_data_nxt;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, w_act_dp_nxt, w_an;
  dig_code_t               w_code;
  assign w_limit = (r_state == ST_BLANK) ? W'(BLANK_CYC - 1) : W'(SCAN_DIV - 1);
  led_tick_gen #(.W(W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .i_limit(w_limit),
    .o_tick (w_tick)
  );
  always_ff @(posedge clk)
    if (!rst_n) r_state <= ST_FIRST;
    else r_state <= w_state_nxt;
  // Outputs are registered from next-cycle values so they change on the same edge as idx/state.
  always_comb begin
    w_state_nxt = r_state;
`ifdef LED_SCAN_BLANK_EN
    w_adv = w_tick && (r_state == ST_DRIVE);
    w_state_nxt = w_tick ? ((r_state == ST_BLANK) ? ST_DRIVE : ST_BLANK) : r_state;
`else
    w_adv = w_tick;
    w_state_nxt = ST_DRIVE;
`endif
    w_wrap = w_adv && (r_idx == LAST);
    w_idx_nxt = w_adv ? (w_wrap ? '0 : r_idx + 1'b1) : r_idx;
    // A load coinciding with the frame boundary bypasses pending so slot 0 shows it at once.
    w_act_data_nxt = w_wrap ? (i_load ? i_data : r_pend_data) : r_act_data;
    w_act_dp_nxt = w_wrap ? (i_load ? i_dp : r_pend_dp) : r_act_dp;
    w_code = '0;
    w_code[DP_BIT] = w_act_dp_nxt[w_idx_nxt];
    w_code[DP_BIT-1:0] = w_act_data_nxt[4*w_idx_nxt +: 4];
    w_an = (en && w_state_nxt == ST_DRIVE) ? ~(NUM_DIGITS'(1) << w_idx_nxt) : '1;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_idx       <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
      o_an        <= '1;
      o_dig_ctrl  <= '0;
      o_frame     <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_act_data <= w_act_data_nxt;
      r_act_dp   <= w_act_dp_nxt;
      if (i_load) begin
        r_pend_data <= i_data;
        r_pend_dp   <= i_dp;
      end
      o_an    <= w_an;
      o_frame <= w_wrap;
      if (en) o_dig_ctrl <= w_code;
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: directed self-checking bench for led_scan_ctrl (4 digits, SCAN_DIV=4, BLANK_CYC=2)
module tb_led_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 4;
`ifdef LED_SCAN_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int SLOT = BLK + SD;
  localparam int FR = ND * SLOT;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic [4:0]  o_dig_ctrl;
  logic [3:0]  o_an;
  logic        o_frame;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  led_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .i_data    (i_data),
    .i_dp      (i_dp),
    .i_load    (i_load),
    .o_dig_ctrl(o_dig_ctrl),
    .o_an      (o_an),
    .o_frame   (o_frame)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed {frame,an,dig}=%h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_frame();
    for (int i = 0; i < 64; i++) begin
      step();
      if (o_frame) break;
    end
    chk("wait_frame", {9'd0, o_frame}, 10'd1);
  endtask
  task automatic run_frame(input string tag, input logic [19:0] exp, input int la,
                           input logic [19:0] da, input int lb, input logic [19:0] db);
    for (int i = 0; i < FR; i++) begin
      int k = i / SLOT;
      int w = i % SLOT;
      logic [3:0] an = (w < BLK) ? 4'hF : ~(4'b0001 << k);
      chk($sformatf("%s c%0d", tag, i), {o_frame, o_an, o_dig_ctrl},
          {(i == 0), an, exp[16+k], exp[4*k +: 4]});
      i_load = (i == la) || (i == lb);
      {i_dp, i_data} = (i == lb) ? db : da;
      step();
    end
    i_load = 1'b0;
  endtask
  initial begin
    step();
    step();
    rst_n = 1'b1;
    en = 1'b1;
    step();
    i_load = 1'b1;
    {i_dp, i_data} = {4'hF, 16'h9999};
    step();
    i_load = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("reset_mid_drive", {o_frame, o_an, o_dig_ctrl}, {1'b0, 4'hF, 5'h00});
    rst_n = 1'b1;
    wait_frame();
    run_frame("zero", 20'h0, 1, {4'b0010, 16'h1234}, -1, 20'h0);
    run_frame("f1234", {4'b0010, 16'h1234}, 5, {4'h0, 16'h5555}, FR - 1, {4'h0, 16'hABCD});
    run_frame("fABCD", {4'h0, 16'hABCD}, 2, {4'h0, 16'h1111}, 9, {4'h0, 16'h2222});
    run_frame("f2222", {4'h0, 16'h2222}, 1, {4'h0, 16'h4321}, -1, 20'h0);
    for (int i = 0; i < 2 * BLK + SD + 1; i++) step();
    chk("slot1_pre_pause", {o_frame, o_an, o_dig_ctrl}, {1'b0, 4'b1101, 5'h02});
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("paused c%0d", i), {o_frame, o_an, o_dig_ctrl}, {1'b0, 4'hF, 5'h02});
    end
    en = 1'b1;
    step();
    chk("resume_1", {o_frame, o_an, o_dig_ctrl}, {1'b0, 4'b1101, 5'h02});
    step();
    chk("resume_2", {o_frame, o_an, o_dig_ctrl}, {1'b0, 4'b1101, 5'h02});
    step();
    chk("resume_slot2", {o_frame, o_an, o_dig_ctrl}, {1'b0, (BLK > 0) ? 4'hF : 4'b1011, 5'h03});
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
